// File: rtl/mdio_link_ctrl.sv
// mdio_link_ctrl
//   Clause-22 MDIO master for the board's 88E1111 PHYs. A single frame engine
//   is shared by a host command port and an internal poller that periodically
//   reads the PHY-specific status register. The poller turns that status into
//   link state and speed selects for the RGMII TX clock mux at top level.
//
// Ports
//   clk, reset            system clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready   host command handshake (ready only in IDLE)
//   cmd_write             1 = write frame, 0 = read frame
//   cmd_reg, cmd_wdata    register address and write data
//   rsp_valid, rsp_rdata  one-cycle response at the end of a host frame
//   mdc                   MDIO clock, clk/(2*CLK_DIV), held low between frames
//   mdio_out, mdio_oen    pin data and active-low output enable (1 = released)
//   mdio_in               pin input
//   link_up               PHY real-time link (status bit 10)
//   eth_mode              1 = 1000 Mb/s
//   ena_10                1 = 10 Mb/s (only meaningful when eth_mode = 0)
//   busy                  frame in progress
module mdio_link_ctrl #(
  parameter int unsigned CLK_DIV     = 25,
  parameter logic [4:0]  PHY_ADDR    = 5'd0,
  parameter logic [4:0]  STAT_REG    = 5'd17,
  parameter logic [23:0] POLL_CYCLES = 24'd5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic        mdio_in,
  output logic        link_up,
  output logic        eth_mode,
  output logic        ena_10,
  output logic        busy
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_CMD  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt;
  logic [63:0]       shreg;
  logic              is_read;
  logic              is_host;
  logic [15:0]       rdata_sh;
  logic [23:0]       timer;
  logic              poll_pending;

  logic [63:0]       start_frame;
  logic [5:0]        next_bit;
  logic              div_tc;
  logic              timer_tc;

  // Full 64-bit frame image; read frames carry all-ones in TA/DATA because the
  // pin is released there anyway.
  function automatic logic [63:0] build_frame(input logic wr,
                                              input logic [4:0] regad,
                                              input logic [15:0] wdata);
    build_frame = {32'hFFFF_FFFF, 2'b01,
                   (wr ? 2'b01 : 2'b10),
                   PHY_ADDR, regad,
                   (wr ? 2'b10 : 2'b11),
                   (wr ? wdata : 16'hFFFF)};
  endfunction

  // Host command has priority over a pending poll when choosing the next frame.
  assign start_frame = cmd_valid ? build_frame(cmd_write, cmd_reg, cmd_wdata)
                                 : build_frame(1'b0, STAT_REG, 16'h0000);
  assign next_bit = bit_cnt + 6'd1;
  assign div_tc   = (div_cnt == DIV_LAST);
  assign timer_tc = (timer == (POLL_CYCLES - 24'd1));

  // Free-running poll interval timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= 24'd0;
    end else if (timer_tc) begin
      timer <= 24'd0;
    end else begin
      timer <= timer + 24'd1;
    end
  end

  // Frame engine: arbitration, MDC generation, bit shifting and status decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= 6'd0;
      shreg        <= 64'd0;
      is_read      <= 1'b0;
      is_host      <= 1'b0;
      rdata_sh     <= 16'd0;
      poll_pending <= 1'b1;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 16'd0;
      mdc          <= 1'b0;
      mdio_out     <= 1'b1;
      mdio_oen     <= 1'b1;
      link_up      <= 1'b0;
      eth_mode     <= 1'b0;
      ena_10       <= 1'b0;
    end else begin
      rsp_valid    <= 1'b0;
      // A timer expiry only ever raises the request; it is consumed at poll start.
      poll_pending <= poll_pending | timer_tc;
      case (state)
        S_IDLE: begin
          mdc     <= 1'b0;
          div_cnt <= '0;
          if (cmd_valid || poll_pending) begin
            state     <= S_PRE;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            bit_cnt   <= 6'd0;
            mdio_out  <= start_frame[63];
            mdio_oen  <= 1'b0;
            shreg     <= {start_frame[62:0], 1'b1};
            rdata_sh  <= 16'd0;
            is_read   <= cmd_valid ? ~cmd_write : 1'b1;
            is_host   <= cmd_valid;
            if (!cmd_valid) begin
              poll_pending <= timer_tc;
            end else begin
              poll_pending <= poll_pending | timer_tc;
            end
          end else begin
            mdio_out <= 1'b1;
            mdio_oen <= 1'b1;
          end
        end
        S_PRE, S_CMD, S_TA, S_DATA: begin
          if (div_tc) begin
            div_cnt <= '0;
            mdc     <= ~mdc;
            if (!mdc) begin
              // MDC rising: capture read data from the PHY.
              if ((state == S_DATA) && is_read) begin
                rdata_sh <= {rdata_sh[14:0], mdio_in};
              end else begin
                rdata_sh <= rdata_sh;
              end
            end else if (bit_cnt == 6'd63) begin
              // Falling edge after the last bit: release the pin and report.
              state    <= S_DONE;
              mdio_out <= 1'b1;
              mdio_oen <= 1'b1;
              if (is_host) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= is_read ? rdata_sh : 16'h0000;
              end else begin
                link_up <= rdata_sh[10];
                if (rdata_sh[10]) begin
                  case (rdata_sh[15:14])
                    2'b10:   begin eth_mode <= 1'b1; ena_10 <= 1'b0; end
                    2'b01:   begin eth_mode <= 1'b0; ena_10 <= 1'b0; end
                    2'b00:   begin eth_mode <= 1'b0; ena_10 <= 1'b1; end
                    default: begin eth_mode <= eth_mode; ena_10 <= ena_10; end
                  endcase
                end else begin
                  eth_mode <= eth_mode;
                  ena_10   <= ena_10;
                end
              end
            end else begin
              // MDC falling: present the next frame bit.
              bit_cnt  <= next_bit;
              mdio_out <= shreg[63];
              shreg    <= {shreg[62:0], 1'b1};
              mdio_oen <= (next_bit >= 6'd46) ? is_read : 1'b0;
              if (next_bit == 6'd32) begin
                state <= S_CMD;
              end else if (next_bit == 6'd46) begin
                state <= S_TA;
              end else if (next_bit == 6'd48) begin
                state <= S_DATA;
              end else begin
                state <= state;
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          mdc       <= 1'b0;
          mdio_out  <= 1'b1;
          mdio_oen  <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          mdc       <= 1'b0;
          mdio_out  <= 1'b1;
          mdio_oen  <= 1'b1;
        end
      endcase
    end
  end

endmodule
